// File: rtl/grf_wb.sv
// rtl/grf_wb.sv - register file with write-through read bypass and commit trace FIFO
module grf_wb #(
  parameter int TRACE_DEPTH = 4,
  parameter int TRACE_AW    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite,
  input  logic [4:0]  WA,
  input  logic [31:0] WD,
  input  logic [31:0] WPC,
  input  logic [4:0]  RA1,
  input  logic [4:0]  RA2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [4:0]  trace_wa,
  output logic [31:0] trace_wd,
  output logic        trace_overflow
);

  localparam logic [TRACE_AW:0]   LP_DEPTH  = (TRACE_AW+1)'(TRACE_DEPTH);
  localparam logic [TRACE_AW:0]   LP_CNT1   = (TRACE_AW+1)'(1);
  localparam logic [TRACE_AW-1:0] LP_PTR1   = TRACE_AW'(1);

  logic [31:0]         r_regs [32];
  logic [31:0]         r_tpc  [TRACE_DEPTH];
  logic [4:0]          r_twa  [TRACE_DEPTH];
  logic [31:0]         r_twd  [TRACE_DEPTH];
  logic [TRACE_AW-1:0] r_rd_ptr;
  logic [TRACE_AW-1:0] r_wr_ptr;
  logic [TRACE_AW:0]   r_count;
  logic                r_overflow;

  logic w_commit;
  logic w_full;
  logic w_pop;
  logic w_push;

  // Register 0 is hardwired, so a write to it is not a commit and is never traced.
  assign w_commit = RegWrite && (WA != 5'd0);
  assign w_full   = (r_count == LP_DEPTH);
  assign w_pop    = trace_valid && trace_ready;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept a push.
  assign w_push   = w_commit && (!w_full || w_pop);

  // Read ports: register 0 reads zero, a same-cycle commit to the address bypasses storage.
  always_comb begin
    RD1 = r_regs[RA1];
    RD2 = r_regs[RA2];
    if (RA1 == 5'd0)
      RD1 = 32'd0;
    else if (w_commit && (WA == RA1))
      RD1 = WD;
    if (RA2 == 5'd0)
      RD2 = 32'd0;
    else if (w_commit && (WA == RA2))
      RD2 = WD;
  end

  // Register file update; reset clears every register and blocks the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        r_regs[i] <= 32'd0;
    end else if (w_commit) begin
      r_regs[WA] <= WD;
    end
  end

  // Trace FIFO storage; cleared on reset so head outputs are never undefined.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TRACE_DEPTH; i++) begin
        r_tpc[i] <= 32'd0;
        r_twa[i] <= 5'd0;
        r_twd[i] <= 32'd0;
      end
    end else if (w_push) begin
      r_tpc[r_wr_ptr] <= WPC;
      r_twa[r_wr_ptr] <= WA;
      r_twd[r_wr_ptr] <= WD;
    end
  end

  // Trace FIFO pointers, occupancy and sticky overflow on a dropped commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + LP_PTR1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + LP_PTR1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CNT1;
        2'b01:   r_count <= r_count - LP_CNT1;
        default: r_count <= r_count;
      endcase
      if (w_commit && !w_push)
        r_overflow <= 1'b1;
    end
  end

  assign trace_valid    = (r_count != '0);
  assign trace_pc       = r_tpc[r_rd_ptr];
  assign trace_wa       = r_twa[r_rd_ptr];
  assign trace_wd       = r_twd[r_rd_ptr];
  assign trace_overflow = r_overflow;

endmodule

// File: tb/tb_grf_wb.sv
// tb/tb_grf_wb.sv - directed table-driven bench for grf_wb
module tb_grf_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WA;
  logic [31:0] WD;
  logic [31:0] WPC;
  logic [4:0]  RA1;
  logic [4:0]  RA2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [4:0]  trace_wa;
  logic [31:0] trace_wd;
  logic        trace_overflow;

  int total = 0;
  int bad   = 0;

  grf_wb #(.TRACE_DEPTH(4), .TRACE_AW(2)) dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WA(WA), .WD(WD), .WPC(WPC),
    .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
    .trace_wa(trace_wa), .trace_wd(trace_wd), .trace_overflow(trace_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] wpc;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        rdy;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic        e_tv;
    logic [31:0] e_pc;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_ov;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic we, logic [4:0] wa, logic [31:0] wd,
                              logic [31:0] wpc, logic [4:0] ra1, logic [4:0] ra2, logic rdy,
                              logic [31:0] e_rd1, logic [31:0] e_rd2, logic e_tv,
                              logic [31:0] e_pc, logic [4:0] e_wa, logic [31:0] e_wd,
                              logic e_ov);
    vec_t v;
    v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.wpc = wpc;
    v.ra1 = ra1; v.ra2 = ra2; v.rdy = rdy;
    v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_tv = e_tv;
    v.e_pc = e_pc; v.e_wa = e_wa; v.e_wd = e_wd; v.e_ov = e_ov;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and let combinational outputs settle.
  task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [31:0] wpc,
                      input logic [4:0] ra1, input logic [4:0] ra2, input logic rdy);
    @(negedge clk);
    reset = rst; RegWrite = we; WA = wa; WD = wd; WPC = wpc;
    RA1 = ra1; RA2 = ra2; trace_ready = rdy;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; RegWrite = 1'b0; WA = 5'd0; WD = 32'd0; WPC = 32'd0;
    RA1 = 5'd0; RA2 = 5'd0; trace_ready = 1'b0;

    //            rst we wa  wd            wpc       ra1 ra2 rdy  e_rd1         e_rd2         tv pc        wa  wd            ov
    tbl.push_back(mk(0, 1, 5, 32'h12345678, 32'h3000, 5, 0, 0, 32'h12345678, 32'h0,        0, 32'h0,    0,  32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,    5, 5, 0, 32'h12345678, 32'h12345678, 1, 32'h3000, 5,  32'h12345678, 0));
    tbl.push_back(mk(0, 1, 0, 32'hFFFFFFFF, 32'h3004, 0, 5, 0, 32'h0,        32'h12345678, 1, 32'h3000, 5,  32'h12345678, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,    0, 0, 1, 32'h0,        32'h0,        1, 32'h3000, 5,  32'h12345678, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,    0, 0, 1, 32'h0,        32'h0,        0, 32'h0,    0,  32'h0,        0));
    tbl.push_back(mk(0, 1, 1, 32'h1,        32'h1001, 1, 5, 0, 32'h1,        32'h12345678, 0, 32'h0,    0,  32'h0,        0));
    tbl.push_back(mk(0, 1, 2, 32'h2,        32'h1002, 2, 5, 0, 32'h2,        32'h12345678, 1, 32'h1001, 1,  32'h1,        0));
    tbl.push_back(mk(0, 1, 3, 32'h3,        32'h1003, 3, 5, 0, 32'h3,        32'h12345678, 1, 32'h1001, 1,  32'h1,        0));
    tbl.push_back(mk(0, 1, 4, 32'h4,        32'h1004, 4, 5, 0, 32'h4,        32'h12345678, 1, 32'h1001, 1,  32'h1,        0));
    tbl.push_back(mk(0, 1, 5, 32'h5,        32'h1005, 1, 5, 0, 32'h1,        32'h5,        1, 32'h1001, 1,  32'h1,        0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,    5, 4, 1, 32'h5,        32'h4,        1, 32'h1001, 1,  32'h1,        1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,    1, 2, 1, 32'h1,        32'h2,        1, 32'h1002, 2,  32'h2,        1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,    3, 0, 1, 32'h3,        32'h0,        1, 32'h1003, 3,  32'h3,        1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,    0, 0, 1, 32'h0,        32'h0,        1, 32'h1004, 4,  32'h4,        1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,    0, 0, 0, 32'h0,        32'h0,        0, 32'h0,    0,  32'h0,        1));
    tbl.push_back(mk(1, 0, 0, 32'h0,        32'h0,    5, 0, 0, 32'h5,        32'h0,        0, 32'h0,    0,  32'h0,        1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,    5, 1, 0, 32'h0,        32'h0,        0, 32'h0,    0,  32'h0,        0));
    tbl.push_back(mk(0, 1, 10, 32'hB0,      32'h2000, 10, 0, 0, 32'hB0,      32'h0,        0, 32'h0,    0,  32'h0,        0));
    tbl.push_back(mk(0, 1, 11, 32'hB1,      32'h2001, 11, 0, 0, 32'hB1,      32'h0,        1, 32'h2000, 10, 32'hB0,       0));
    tbl.push_back(mk(0, 1, 12, 32'hB2,      32'h2002, 12, 0, 0, 32'hB2,      32'h0,        1, 32'h2000, 10, 32'hB0,       0));
    tbl.push_back(mk(0, 1, 13, 32'hB3,      32'h2003, 13, 0, 0, 32'hB3,      32'h0,        1, 32'h2000, 10, 32'hB0,       0));
    tbl.push_back(mk(0, 1, 7, 32'hA5,       32'h2007, 7, 13, 1, 32'hA5,      32'hB3,       1, 32'h2000, 10, 32'hB0,       0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,    7, 10, 1, 32'hA5,      32'hB0,       1, 32'h2001, 11, 32'hB1,       0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,    0, 0, 1, 32'h0,        32'h0,        1, 32'h2002, 12, 32'hB2,       0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,    0, 0, 1, 32'h0,        32'h0,        1, 32'h2003, 13, 32'hB3,       0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,    0, 0, 1, 32'h0,        32'h0,        1, 32'h2007, 7,  32'hA5,       0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,    0, 0, 0, 32'h0,        32'h0,        0, 32'h0,    0,  32'h0,        0));

    // Two reset edges, then every register reads zero on both ports.
    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 0, 0, 5'(i), 5'(31 - i), 0);
      cmp($sformatf("reset_rd1_r%0d", i), RD1, 32'd0);
      cmp($sformatf("reset_rd2_r%0d", 31 - i), RD2, 32'd0);
    end
    cmp("reset_trace_valid", {31'd0, trace_valid}, 32'd0);
    cmp("reset_overflow", {31'd0, trace_overflow}, 32'd0);

    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].rst, tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].wpc,
           tbl[k].ra1, tbl[k].ra2, tbl[k].rdy);
      cmp($sformatf("v%0d_rd1", k), RD1, tbl[k].e_rd1);
      cmp($sformatf("v%0d_rd2", k), RD2, tbl[k].e_rd2);
      cmp($sformatf("v%0d_tvalid", k), {31'd0, trace_valid}, {31'd0, tbl[k].e_tv});
      cmp($sformatf("v%0d_overflow", k), {31'd0, trace_overflow}, {31'd0, tbl[k].e_ov});
      if (tbl[k].e_tv) begin
        cmp($sformatf("v%0d_tpc", k), trace_pc, tbl[k].e_pc);
        cmp($sformatf("v%0d_twa", k), {27'd0, trace_wa}, {27'd0, tbl[k].e_wa});
        cmp($sformatf("v%0d_twd", k), trace_wd, tbl[k].e_wd);
      end
    end

    // Reset in the middle of traffic: full FIFO, overflow set, then reset with a write pending.
    step(0, 1, 20, 32'h20, 32'h4000, 0, 0, 0);
    step(0, 1, 21, 32'h21, 32'h4004, 0, 0, 0);
    step(0, 1, 22, 32'h22, 32'h4008, 0, 0, 0);
    step(0, 1, 9, 32'hDEAD, 32'h400C, 9, 0, 0);
    cmp("mid_bypass_r9", RD1, 32'hDEAD);
    step(0, 1, 23, 32'h23, 32'h4010, 9, 0, 0);
    cmp("mid_r9", RD1, 32'hDEAD);
    cmp("mid_full_valid", {31'd0, trace_valid}, 32'd1);
    cmp("mid_pre_overflow", {31'd0, trace_overflow}, 32'd0);
    step(0, 0, 0, 0, 0, 9, 23, 0);
    cmp("mid_overflow", {31'd0, trace_overflow}, 32'd1);
    cmp("mid_r23", RD2, 32'h23);
    cmp("mid_head_pc", trace_pc, 32'h4000);
    cmp("mid_head_wa", {27'd0, trace_wa}, 32'd20);
    step(1, 1, 9, 32'hBEEF, 32'h4014, 9, 20, 1);
    step(0, 0, 0, 0, 0, 9, 20, 0);
    cmp("post_reset_r9", RD1, 32'd0);
    cmp("post_reset_r20", RD2, 32'd0);
    cmp("post_reset_valid", {31'd0, trace_valid}, 32'd0);
    cmp("post_reset_overflow", {31'd0, trace_overflow}, 32'd0);
    step(0, 0, 0, 0, 0, 9, 22, 1);
    cmp("post_reset_r9_again", RD1, 32'd0);
    cmp("post_reset_r22", RD2, 32'd0);
    cmp("post_reset_valid_again", {31'd0, trace_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
